e203_tcm_sram_ctrl: RTL and testbench
=====================================

E203_TCM_SRAM_CTRL -- requirements
Module: e203_tcm_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16, meaning ICB byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; MW = DW/8 byte-mask width.
REQ-003 SHALL have parameter RAM_AW, default 14, meaning SRAM word-address width (AW-2).
REQ-004 SHALL have parameter RAM_DP, default 16384, meaning valid word depth; RAM_DP <= 2**RAM_AW.
REQ-005 SHALL have parameter IDLE_LS_CYC, default 16, meaning idle cycles before light-sleep entry.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 test_mode  input  1  1 disables light-sleep entry.
REQ-009 i_icb_cmd_valid / i_icb_cmd_ready  input / output  1 / 1  command handshake.
REQ-010 i_icb_cmd_addr  input  AW  byte address; bits [1:0] ignored.
REQ-011 i_icb_cmd_read  input  1  1 = read, 0 = write.
REQ-012 i_icb_cmd_wdata / i_icb_cmd_wmask  input  DW / MW  write data and byte mask.
REQ-013 i_icb_rsp_valid / i_icb_rsp_ready  output / input  1 / 1  response handshake.
REQ-014 i_icb_rsp_rdata / i_icb_rsp_err  output  DW / 1  read data; error flag.
REQ-015 ram_cs, ram_we  output  1  SRAM chip select, write enable.
REQ-016 ram_addr / ram_wem / ram_din  output  RAM_AW / MW / DW  SRAM word address, write mask, write data.
REQ-017 ram_dout  input  DW  SRAM read data, valid the cycle after a cs+!we cycle.
REQ-018 ram_sd, ram_ds, ram_ls  output  1  shutdown, deep-sleep, light-sleep controls.

Function
REQ-019 Command SHALL be accepted on cycle with i_icb_cmd_valid & i_icb_cmd_ready; ram_cs=1 that same cycle (combinational), with ram_we=!read, ram_addr=addr[RAM_AW+1:2], ram_wem=read?0:wmask, ram_din=wdata.
REQ-020 Address with addr[AW-1:2] >= RAM_DP SHALL be accepted with ram_cs=0 and answered with err=1, rdata=0.
REQ-021 i_icb_cmd_ready SHALL equal (state==ACTIVE) & (!rsp_valid | i_icb_rsp_ready); at most one outstanding response.
REQ-022 i_icb_rsp_valid SHALL rise exactly 1 cycle after acceptance; back-to-back accept SHALL sustain 1 transaction/cycle when rsp_ready=1.
REQ-023 Read rdata SHALL come from ram_dout in the first response cycle and from an internal capture register on every stalled cycle thereafter; rdata SHALL stay stable while rsp_valid & !rsp_ready.
REQ-024 Write response SHALL carry rdata=0, err=0.
REQ-025 FSM states ACTIVE, LS, WAKE. ACTIVE->LS when idle counter reaches IDLE_LS_CYC and test_mode=0; LS->WAKE on i_icb_cmd_valid; WAKE->ACTIVE unconditionally next cycle.
REQ-026 Idle counter SHALL clear on any cmd_valid or rsp_valid, otherwise increment and saturate at IDLE_LS_CYC.
REQ-027 ram_ls SHALL be 1 only in LS; cmd_ready=0 in LS and WAKE; ram_sd=ram_ds=0 always.
REQ-028 test_mode=1 while in LS SHALL force transition to WAKE.

Reset
REQ-029 On rst=1 at a clk edge: state=ACTIVE, idle counter=0, rsp_valid=0, rsp_err=0, capture register=0; ram_cs/we/ls=0.
REQ-030 rst asserted mid-transaction SHALL drop a pending response without a handshake.

Structure
REQ-031 FSM state enum and default IDLE_LS_CYC SHALL live in shared package e203_tcm_pkg.
REQ-032 Response holding stage SHALL be one sub-module e203_tcm_rsp_buf (valid, err, data capture, bypass select).

Verification
REQ-033 Write addr 0x0010 wdata 0xA5A5_5A5A wmask 0xF, then read 0x0010 -> cycle0 cs=1 we=1 ram_addr=4; read rsp one cycle later rdata 0xA5A5_5A5A err=0.
REQ-034 Read with rsp_ready held 0 for 5 cycles while ram_dout toggles -> rdata stays at first-cycle value, cmd_ready=0 throughout.
REQ-035 RAM_DP=1024, read addr 0x1000 -> ram_cs=0, rsp err=1 rdata=0.
REQ-036 20 idle cycles -> ram_ls=1 after cycle 16; then cmd_valid -> ls=0 one cycle (WAKE), cmd accepted next cycle.
REQ-037 test_mode=1, 40 idle cycles -> ram_ls never 1.
REQ-038 Four back-to-back reads with rsp_ready=1 -> four rsp_valid cycles contiguous, rst pulse mid-stream -> rsp_valid=0 next cycle.

Source files
------------

// File: rtl/e203_tcm_pkg.sv
// Shared definitions for the E203 TCM SRAM controller: power-state encoding
// and the default idle threshold before light-sleep entry.
package e203_tcm_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    LS     = 2'd1,
    WAKE   = 2'd2
  } tcm_state_e;

  localparam int DEF_IDLE_LS_CYC = 16;

endpackage

// File: rtl/e203_tcm_sram_ctrl_if.sv
// ICB command/response channel between a bus master and the TCM controller.
interface e203_tcm_sram_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  localparam int MW = DW / 8;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/e203_tcm_rsp_buf.sv
// One-deep response holding stage: bypasses SRAM read data in the first
// response cycle and serves it from a capture register while stalled.
module e203_tcm_rsp_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_hsk,
  input  logic          cmd_read,
  input  logic          cmd_err,
  input  logic          rsp_ready,
  input  logic [DW-1:0] ram_dout,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata
);

  logic          rd_q;
  logic          first_q;
  logic [DW-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_q      <= 1'b0;
      first_q   <= 1'b0;
      // NOTE: cap_q is a single register, not a RAM, so it is reset to keep
      // rdata deterministic after reset.
      cap_q     <= '0;
    end else begin
      first_q <= cmd_hsk;
      if (cmd_hsk) begin
        rsp_valid <= 1'b1;
        rsp_err   <= cmd_err;
        rd_q      <= cmd_read & ~cmd_err;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rd_q      <= 1'b0;
      end
      // SRAM output is only valid in the first response cycle; hold it here.
      if (first_q) cap_q <= ram_dout;
    end
  end

  assign rsp_rdata = rd_q ? (first_q ? ram_dout : cap_q) : '0;

endmodule

// File: rtl/e203_tcm_sram_ctrl.sv
// ICB-to-SRAM controller for the E203 TCM with idle-driven light sleep and
// a single outstanding response.
module e203_tcm_sram_ctrl
  import e203_tcm_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int RAM_AW      = 14,
  parameter int RAM_DP      = 16384,
  parameter int IDLE_LS_CYC = DEF_IDLE_LS_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                test_mode,
  e203_tcm_sram_ctrl_if.slave i_icb,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DW/8-1:0]     ram_wem,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout,
  output logic                ram_sd,
  output logic                ram_ds,
  output logic                ram_ls
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(IDLE_LS_CYC + 1);

  tcm_state_e    state;
  logic [CW-1:0] idle_cnt;
  logic          rsp_valid;
  logic          cmd_hsk;
  logic          in_range;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, i_icb.cmd_addr[1:0]};

  assign in_range        = {1'b0, i_icb.cmd_addr[AW-1:2]} < (AW-1)'(RAM_DP);
  assign i_icb.cmd_ready = (state == ACTIVE) & (~rsp_valid | i_icb.rsp_ready);
  assign cmd_hsk         = i_icb.cmd_valid & i_icb.cmd_ready;

  assign ram_cs   = cmd_hsk & in_range & ~rst;
  assign ram_we   = ram_cs & ~i_icb.cmd_read;
  assign ram_addr = i_icb.cmd_addr[RAM_AW+1:2];
  assign ram_wem  = i_icb.cmd_read ? {MW{1'b0}} : i_icb.cmd_wmask;
  assign ram_din  = i_icb.cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      ram_ls   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so the counter, state and ram_ls all see
      // the same pre-edge values within this block.
      if (i_icb.cmd_valid | rsp_valid)
        idle_cnt <= '0;
      else if (idle_cnt != CW'(IDLE_LS_CYC))
        idle_cnt <= idle_cnt + CW'(1);

      unique case (state)
        ACTIVE: begin
          // Never sleep with a command arriving or a response still owed.
          if (idle_cnt == CW'(IDLE_LS_CYC) && !test_mode &&
              !i_icb.cmd_valid && !rsp_valid) begin
            state  <= LS;
            ram_ls <= 1'b1;
          end
        end
        LS: begin
          if (i_icb.cmd_valid | test_mode) begin
            state  <= WAKE;
            ram_ls <= 1'b0;
          end
        end
        WAKE:    state <= ACTIVE;
        default: begin
          state  <= ACTIVE;
          ram_ls <= 1'b0;
        end
      endcase
    end
  end

  e203_tcm_rsp_buf #(.DW(DW)) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .cmd_hsk   (cmd_hsk),
    .cmd_read  (i_icb.cmd_read),
    .cmd_err   (~in_range),
    .rsp_ready (i_icb.rsp_ready),
    .ram_dout  (ram_dout),
    .rsp_valid (rsp_valid),
    .rsp_err   (i_icb.rsp_err),
    .rsp_rdata (i_icb.rsp_rdata)
  );

  assign i_icb.rsp_valid = rsp_valid;

endmodule

// File: tb/tb_e203_tcm_sram_ctrl.sv
// Directed bench for e203_tcm_sram_ctrl with a behavioural SRAM and a
// response scoreboard fed at command acceptance.
module tb_e203_tcm_sram_ctrl;
  import e203_tcm_pkg::*;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int MW     = DW / 8;
  localparam int RAM_AW = 14;
  localparam int RAM_DP = 1024;

  logic clk = 1'b0;
  logic rst;
  logic test_mode;
  logic ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
  logic [RAM_AW-1:0] ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din, ram_dout;

  e203_tcm_sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  e203_tcm_sram_ctrl #(
    .AW(AW), .DW(DW), .RAM_AW(RAM_AW), .RAM_DP(RAM_DP), .IDLE_LS_CYC(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .test_mode (test_mode),
    .i_icb     (bus.slave),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wem   (ram_wem),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_sd    (ram_sd),
    .ram_ds    (ram_ds),
    .ram_ls    (ram_ls)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM; dout_force lets the bench scramble ram_dout during stalls.
  logic [DW-1:0] mem [0:RAM_DP-1];
  logic [DW-1:0] mdout;
  logic          dout_force;
  logic [DW-1:0] dout_tog;
  assign ram_dout = dout_force ? dout_tog : mdout;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        mdout <= mem[ram_addr[9:0]];
      end
    end
  end

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [0:RAM_DP-1];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
        check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
      end
    end
  end

  // Snapshot of the acceptance cycle of the last issued command.
  logic              s_cs, s_we, s_rv;
  logic [RAM_AW-1:0] s_addr;
  logic [MW-1:0]     s_wem;
  int                s_wait;

  task automatic issue(input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    int n = 0;
    int w;
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = rd;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_wmask = wm;
    #3;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge clk); #4;
      n++;
    end
    s_wait = n;
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    end else begin
      s_cs   = ram_cs;
      s_we   = ram_we;
      s_addr = ram_addr;
      s_wem  = ram_wem;
      s_rv   = bus.rsp_valid;
      w = int'(a[AW-1:2]);
      if (w >= RAM_DP) begin
        exp_q.push_back('{err: 1'b1, rdata: '0});
      end else if (rd) begin
        exp_q.push_back('{err: 1'b0, rdata: ref_mem[w]});
      end else begin
        for (int b = 0; b < MW; b++)
          if (wm[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        exp_q.push_back('{err: 1'b0, rdata: '0});
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic seen;

  initial begin
    for (int i = 0; i < RAM_DP; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mdout         = '0;
    rst           = 1'b1;
    test_mode     = 1'b0;
    dout_force    = 1'b0;
    dout_tog      = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_read  = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wmask = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ram_ls", 32'(ram_ls), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_sd_ds", 32'({ram_sd, ram_ds}), 32'd0);
    @(posedge clk); #1;

    // Full write then read of the same word.
    issue(1'b0, 16'h0010, 32'hA5A5_5A5A, 4'hF);
    check("wr_cs", 32'(s_cs), 32'd1);
    check("wr_we", 32'(s_we), 32'd1);
    check("wr_addr", 32'(s_addr), 32'd4);
    check("wr_wem", 32'(s_wem), 32'hF);
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    check("rd_cs", 32'(s_cs), 32'd1);
    check("rd_we", 32'(s_we), 32'd0);
    check("rd_wem", 32'(s_wem), 32'd0);
    #3;
    check("rd_rsp_valid_next", 32'(bus.rsp_valid), 32'd1);
    check("rd_rdata_first", bus.rsp_rdata, 32'hA5A5_5A5A);
    @(posedge clk); #1;

    // Partial mask write; read with nonzero address LSBs.
    issue(1'b0, 16'h0014, 32'h1122_3344, 4'b0101);
    issue(1'b1, 16'h0017, 32'h0, 4'h0);
    check("rd_lsb_addr", 32'(s_addr), 32'd5);
    @(posedge clk); #1;

    // Stalled read: rdata must hold while ram_dout is scrambled.
    bus.rsp_ready = 1'b0;
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    #3;
    check("stall_first_rdata", bus.rsp_rdata, 32'hA5A5_5A5A);
    check("stall_first_ready", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      dout_force = 1'b1;
      dout_tog   = $urandom;
      #3;
      check("stall_rdata", bus.rsp_rdata, 32'hA5A5_5A5A);
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    dout_force    = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Out-of-range accesses: no SRAM select, error response, no aliasing.
    issue(1'b1, 16'h1000, 32'h0, 4'h0);
    check("oor_rd_cs", 32'(s_cs), 32'd0);
    issue(1'b0, 16'h1000, 32'hDEAD_BEEF, 4'hF);
    check("oor_wr_cs", 32'(s_cs), 32'd0);
    check("oor_wr_we", 32'(s_we), 32'd0);
    issue(1'b1, 16'h0000, 32'h0, 4'h0);

    // Idle into light sleep: 16 idle cycles after the last response.
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 17) check("ls_not_yet", 32'(ram_ls), 32'd0);
      if (n == 18) check("ls_entered", 32'(ram_ls), 32'd1);
    end
    check("ls_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = 1'b1;
    bus.cmd_addr  = 16'h0014;
    #3;
    check("ls_hold_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #3;
    check("wake_ls", 32'(ram_ls), 32'd0);
    check("wake_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #3;
    check("active_ready", 32'(bus.cmd_ready), 32'd1);
    issue(1'b1, 16'h0014, 32'h0, 4'h0);
    check("wake_wait", 32'(s_wait), 32'd0);

    // test_mode while sleeping forces a wake.
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
    end
    check("ls_again", 32'(ram_ls), 32'd1);
    test_mode = 1'b1;
    @(posedge clk); #1;
    check("tm_wake_ls", 32'(ram_ls), 32'd0);
    check("tm_wake_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("tm_active_ready", 32'(bus.cmd_ready), 32'd1);

    // test_mode held: never sleep.
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      seen = seen | ram_ls;
    end
    check("tm_no_ls", 32'(seen), 32'd0);

    // Back-to-back reads at full rate.
    test_mode = 1'b0;
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    check("b2b0_wait", 32'(s_wait), 32'd0);
    issue(1'b1, 16'h0014, 32'h0, 4'h0);
    check("b2b1_wait", 32'(s_wait), 32'd0);
    check("b2b1_rv", 32'(s_rv), 32'd1);
    issue(1'b1, 16'h0000, 32'h0, 4'h0);
    check("b2b2_wait", 32'(s_wait), 32'd0);
    check("b2b2_rv", 32'(s_rv), 32'd1);
    issue(1'b1, 16'h0014, 32'h0, 4'h0);
    check("b2b3_wait", 32'(s_wait), 32'd0);
    check("b2b3_rv", 32'(s_rv), 32'd1);
    #3;
    check("b2b_last_rv", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;

    // Reset while a response is pending drops it.
    bus.rsp_ready = 1'b0;
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    #3;
    check("pend_rv", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_rv", 32'(bus.rsp_valid), 32'd0);
    check("rst_drop_err", 32'(bus.rsp_err), 32'd0);
    void'(exp_q.pop_back());
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      seen = seen | bus.rsp_valid;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
